shift_ctrl: RTL
===============

SHIFT_CTRL -- requirements
Module: shift_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: serial word length in bits; legal range DATA_W >= 2.
REQ-002 Parameter MSB_FIRST, default 1: 1 = MSB transferred first, 0 = LSB transferred first.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 start  in  1  transfer request; accepted only while ready=1.
REQ-006 mode  in  1  0 = SIPO (serial in, parallel out), 1 = PISO (parallel in, serial out); sampled at accept.
REQ-007 par_in  in  DATA_W  parallel word for PISO; sampled at accept.
REQ-008 ser_in  in  1  serial input bit for SIPO; sampled in SHIFT cycles.
REQ-009 abort  in  1  cancels any transfer in progress.
REQ-010 ready  out  1  high only in IDLE.
REQ-011 load  out  1  high only in LOAD.
REQ-012 shift  out  1  high only in SHIFT.
REQ-013 out_valid  out  1  one-cycle strobe in OUTPUT.
REQ-014 ser_out  out  1  serial output bit for PISO.
REQ-015 par_out  out  DATA_W  assembled SIPO word.

Function
REQ-016 The block SHALL implement a Moore FSM with states IDLE, LOAD, SHIFT and OUTPUT; ready, load, shift and out_valid are decoded from the current state only.
REQ-017 Accept: in IDLE with start=1, the next edge SHALL enter LOAD and capture mode into mode_q; in PISO it SHALL also capture par_in into the shift register.
REQ-018 LOAD SHALL last exactly one cycle, clear the bit counter to 0 and transition to SHIFT.
REQ-019 SHIFT SHALL last exactly DATA_W cycles; the counter (width $clog2(DATA_W)) increments once per cycle; at count DATA_W-1 the next state is OUTPUT.
REQ-020 PISO, in SHIFT: ser_out SHALL equal shreg[DATA_W-1] (MSB_FIRST=1) or shreg[0] (MSB_FIRST=0); each edge shifts the register one place toward that end, zero-filling.
REQ-021 ser_out SHALL be 0 outside SHIFT and in SIPO mode.
REQ-022 SIPO, each SHIFT edge: shreg <= {shreg[DATA_W-2:0], ser_in} (MSB_FIRST=1) or {ser_in, shreg[DATA_W-1:1]} (MSB_FIRST=0).
REQ-023 On entry to OUTPUT in SIPO mode, par_out SHALL take the final shreg value. par_out SHALL otherwise hold, and SHALL never change in PISO mode.
REQ-024 OUTPUT SHALL last exactly one cycle, then return to IDLE.
REQ-025 Latency: accept edge T; LOAD in cycle T+1; SHIFT in T+2..T+1+DATA_W; out_valid in T+2+DATA_W; ready=1 again in T+3+DATA_W.
REQ-026 start SHALL be ignored outside IDLE; with start held high, transfers SHALL run back-to-back, one every DATA_W+3 cycles.
REQ-027 abort=1 in LOAD, SHIFT or OUTPUT SHALL force IDLE on the next edge, with no out_valid, counter cleared and par_out unchanged.
REQ-028 abort SHALL have priority over start, so abort=1 in IDLE blocks acceptance.
REQ-029 Unreachable state encodings SHALL recover to IDLE on the next edge.

Reset
REQ-030 While rst=1, the next edge SHALL set state=IDLE, counter=0, shreg=0, mode_q=0 and par_out=0; rst has priority over abort and start.
REQ-031 After reset, outputs SHALL be ready=1 and load=shift=out_valid=ser_out=0; rst asserted mid-transfer SHALL discard that transfer without an out_valid.

Structure
REQ-032 Package shift_ctrl_pkg SHALL hold the state_t enum (IDLE=2'b00, LOAD=2'b01, SHIFT=2'b10, OUTPUT=2'b11) and the constants MODE_SIPO=1'b0 and MODE_PISO=1'b1.
REQ-033 The bit counter SHALL be a sub-module, shift_bit_counter, with clear, enable and terminal-count outputs, parametrised by DATA_W.

Verification (DATA_W=8 unless noted)
REQ-034 PISO, MSB_FIRST=1, par_in=8'hA5, 1-cycle start -> ser_out 1,0,1,0,0,1,0,1 over 8 shift cycles; out_valid at T+10; par_out unchanged.
REQ-035 SIPO, MSB_FIRST=1, ser_in 1,1,0,0,1,0,1,0 -> par_out=8'hCA with out_valid at T+10; ready at T+11.
REQ-036 PISO, MSB_FIRST=0, par_in=8'h01 -> ser_out 1 then seven 0s.
REQ-037 start held high for 30 cycles, plus extra start pulses mid-SHIFT -> accepts at T, T+11 and T+22 only; extra pulses ignored.
REQ-038 abort in the 3rd SHIFT cycle -> IDLE and ready=1 next cycle; no out_valid; par_out keeps its prior value, e.g. 8'hCA.
REQ-039 rst=1 during SHIFT -> next edge shows every output at its reset value; no out_valid follows.

Source files
------------

// File: rtl/shift_ctrl_pkg.sv
// Shared state encoding and mode constants for the shift_ctrl serial/parallel converter.
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOAD   = 2'b01,
    SHIFT  = 2'b10,
    OUTPUT = 2'b11
  } state_t;

  localparam logic MODE_SIPO = 1'b0;
  localparam logic MODE_PISO = 1'b1;

endpackage

// File: rtl/shift_bit_counter.sv
// Bit counter for the SHIFT phase; tc flags the last bit of a DATA_W-bit word.
module shift_bit_counter #(
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/shift_ctrl.sv
// Moore-FSM controlled shift register: SIPO assembles a word from ser_in, PISO streams par_in on ser_out.
module shift_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] par_in,
  input  logic              ser_in,
  input  logic              abort,
  output logic              ready,
  output logic              load,
  output logic              shift,
  output logic              out_valid,
  output logic              ser_out,
  output logic [DATA_W-1:0] par_out
);

  state_t            state;
  state_t            state_next;
  logic              mode_q;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_shifted;
  logic              cnt_tc;
  logic              accept;
  logic              advance;

  assign accept  = (state == IDLE) && start && !abort;
  assign advance = (state == SHIFT) && !abort;

  // Counter is held at zero whenever we are not actively shifting, which covers LOAD and abort.
  shift_bit_counter #(.DATA_W(DATA_W)) u_bit_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  ((state != SHIFT) || abort),
    .enable (advance),
    .tc     (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (accept) state_next = LOAD;
      end
      LOAD: begin
        load       = 1'b1;
        state_next = abort ? IDLE : SHIFT;
      end
      SHIFT: begin
        shift = 1'b1;
        if (abort)       state_next = IDLE;
        else if (cnt_tc) state_next = OUTPUT;
      end
      OUTPUT: begin
        out_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // PISO shifts toward the output end with zero fill; SIPO shifts ser_in in from the opposite end.
  always_comb begin
    shreg_shifted = shreg;
    if (mode_q == MODE_PISO) begin
      shreg_shifted = MSB_FIRST ? {shreg[DATA_W-2:0], 1'b0} : {1'b0, shreg[DATA_W-1:1]};
    end else begin
      shreg_shifted = MSB_FIRST ? {shreg[DATA_W-2:0], ser_in} : {ser_in, shreg[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= MODE_SIPO;
      shreg   <= '0;
      par_out <= '0;
    end else if (accept) begin
      mode_q <= mode;
      if (mode == MODE_PISO) shreg <= par_in;
    end else if (advance) begin
      shreg <= shreg_shifted;
      if (cnt_tc && (mode_q == MODE_SIPO)) par_out <= shreg_shifted;
    end
  end

  assign ser_out = ((state == SHIFT) && (mode_q == MODE_PISO))
                 ? (MSB_FIRST ? shreg[DATA_W-1] : shreg[0])
                 : 1'b0;

endmodule
